// File: rtl/isa_types.sv
// Shared ISA-level types for the hart datapath and the load/store unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package isa_types;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  // Access size of a load or store.
  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } write_width_t;

  // Load/store unit sequencing.
  typedef enum logic [1:0] {
    LSU_IDLE     = 2'd0,
    LSU_ISSUE    = 2'd1,
    LSU_WAIT_RSP = 2'd2,
    LSU_RESP     = 2'd3
  } lsu_state_t;

  // One word-aligned data memory transaction.
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic              we;
    logic [STRB_W-1:0] wstrb;
    logic [XLEN-1:0]   wdata;
  } mem_req_t;

  // Halfwords need an even address, words a 4-byte aligned one. The unused
  // encoding is treated like a word so it can never slip through unaligned.
  function automatic logic is_misaligned(write_width_t width, logic [1:0] offset);
    case (width)
      WIDTH_BYTE: return 1'b0;
      WIDTH_HALF: return offset[0];
      default:    return (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store strobes/data shift, load lane extract and extension.
// Latency: purely combinational.
// Backpressure: none (no state).
module ls_lane_align
  import isa_types::*;
#(
  parameter int XLEN   = isa_types::XLEN,
  parameter int STRB_W = XLEN / 8
) (
  input  write_width_t      width,
  input  logic [1:0]        offset,
  input  logic              is_unsigned,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   wdata_shifted,
  output logic [XLEN-1:0]   rdata_ext
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] lane;

  assign shamt         = {offset, 3'b000};
  assign wdata_shifted = wdata << shamt;
  assign lane          = rdata >> shamt;

  // Strobes cover the bytes the store touches within the word.
  always_comb begin
    wstrb = '0;
    case (width)
      WIDTH_BYTE: wstrb = {{(STRB_W-1){1'b0}}, 1'b1} << offset;
      WIDTH_HALF: wstrb = {{(STRB_W-2){1'b0}}, 2'b11} << offset;
      default:    wstrb = '1;
    endcase
  end

  // Truncate the extracted lane to the access size, then extend; words ignore is_unsigned.
  always_comb begin
    rdata_ext = lane;
    case (width)
      WIDTH_BYTE: rdata_ext = is_unsigned ? {{(XLEN-8){1'b0}}, lane[7:0]}
                                          : {{(XLEN-8){lane[7]}}, lane[7:0]};
      WIDTH_HALF: rdata_ext = is_unsigned ? {{(XLEN-16){1'b0}}, lane[15:0]}
                                          : {{(XLEN-16){lane[15]}}, lane[15:0]};
      default:    rdata_ext = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one request at a time -> aligned memory transaction -> completion.
// Latency: misaligned 1 cycle, store 2 cycles, load 3 cycles (zero-wait memory).
// Backpressure: req_ready only in IDLE; mem_* held until mem_req_ready; resp held until resp_ready.
module mem_access_unit
  import isa_types::*;
#(
  parameter int XLEN   = isa_types::XLEN,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  write_width_t      req_width,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misaligned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t      state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_misaligned_q, resp_misaligned_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  mem_req_t        mem_req_q, mem_req_d;

  // Captured request fields
  logic            is_store_q, is_store_d;
  write_width_t    width_q, width_d;
  logic            unsigned_q, unsigned_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  // One aligner serves both paths: in IDLE it shapes the incoming store,
  // afterwards it sees the captured request to extend the returning load.
  write_width_t      al_width;
  logic [1:0]        al_offset;
  logic              al_unsigned;
  logic [XLEN-1:0]   al_wdata;
  logic [STRB_W-1:0] al_wstrb_o;
  logic [XLEN-1:0]   al_wdata_o;
  logic [XLEN-1:0]   al_rdata_o;
  logic              in_idle;

  assign in_idle     = (state_q == LSU_IDLE);
  assign al_width    = in_idle ? req_width       : width_q;
  assign al_offset   = in_idle ? req_addr[1:0]   : addr_q[1:0];
  assign al_unsigned = in_idle ? req_unsigned    : unsigned_q;
  assign al_wdata    = in_idle ? req_wdata       : wdata_q;

  ls_lane_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
    .width         (al_width),
    .offset        (al_offset),
    .is_unsigned   (al_unsigned),
    .wdata         (al_wdata),
    .rdata         (mem_rdata),
    .wstrb         (al_wstrb_o),
    .wdata_shifted (al_wdata_o),
    .rdata_ext     (al_rdata_o)
  );

  // Next-state and registered-output logic for the request sequencer.
  always_comb begin
    state_d           = state_q;
    req_ready_d       = req_ready_q;
    resp_valid_d      = resp_valid_q;
    resp_rdata_d      = resp_rdata_q;
    resp_misaligned_d = resp_misaligned_q;
    mem_req_valid_d   = mem_req_valid_q;
    mem_req_d         = mem_req_q;
    is_store_d        = is_store_q;
    width_d           = width_q;
    unsigned_d        = unsigned_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;

    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          is_store_d   = req_is_store;
          width_d      = req_width;
          unsigned_d   = req_unsigned;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          req_ready_d  = 1'b0;
          resp_rdata_d = '0;
          if (is_misaligned(req_width, req_addr[1:0])) begin
            // Faults never reach memory.
            resp_valid_d      = 1'b1;
            resp_misaligned_d = 1'b1;
            state_d           = LSU_RESP;
          end else begin
            resp_misaligned_d = 1'b0;
            mem_req_valid_d   = 1'b1;
            mem_req_d.addr    = {req_addr[XLEN-1:2], 2'b00};
            mem_req_d.we      = req_is_store;
            mem_req_d.wstrb   = req_is_store ? al_wstrb_o : '0;
            mem_req_d.wdata   = req_is_store ? al_wdata_o : '0;
            state_d           = LSU_ISSUE;
          end
        end
      end
      LSU_ISSUE: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          mem_req_d       = '0;
          if (is_store_q) begin
            resp_valid_d = 1'b1;
            state_d      = LSU_RESP;
          end else begin
            state_d      = LSU_WAIT_RSP;
          end
        end
      end
      LSU_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          resp_rdata_d = al_rdata_o;
          resp_valid_d = 1'b1;
          state_d      = LSU_RESP;
        end
      end
      default: begin
        if (resp_ready) begin
          resp_valid_d      = 1'b0;
          resp_rdata_d      = '0;
          resp_misaligned_d = 1'b0;
          req_ready_d       = 1'b1;
          state_d           = LSU_IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= LSU_IDLE;
      req_ready_q       <= 1'b1;
      resp_valid_q      <= 1'b0;
      resp_rdata_q      <= '0;
      resp_misaligned_q <= 1'b0;
      mem_req_valid_q   <= 1'b0;
      mem_req_q         <= '0;
      is_store_q        <= 1'b0;
      width_q           <= WIDTH_BYTE;
      unsigned_q        <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
    end else begin
      state_q           <= state_d;
      req_ready_q       <= req_ready_d;
      resp_valid_q      <= resp_valid_d;
      resp_rdata_q      <= resp_rdata_d;
      resp_misaligned_q <= resp_misaligned_d;
      mem_req_valid_q   <= mem_req_valid_d;
      mem_req_q         <= mem_req_d;
      is_store_q        <= is_store_d;
      width_q           <= width_d;
      unsigned_q        <= unsigned_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_misaligned_q;
  assign mem_req_valid   = mem_req_valid_q;
  assign mem_addr        = mem_req_q.addr;
  assign mem_we          = mem_req_q.we;
  assign mem_wstrb       = mem_req_q.wstrb;
  assign mem_wdata       = mem_req_q.wdata;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store stage between the hart's execute logic and the data memory port. It accepts one OP_LOAD/OP_STORE request at a time, sized by write_width_t (byte/halfword/word). It issues a word-aligned memory transaction with byte strobes, then returns the load data with lane alignment and sign/zero extension, or a store acknowledge. Misaligned accesses are rejected without touching memory.

Parameters:
XLEN, 32, data and address width; must equal isa_types::XLEN.
STRB_W, XLEN/8, number of byte strobes.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request offered by the hart
req_ready  output  1  unit can accept a request
req_is_store  input  1  1=store, 0=load
req_width  input  write_width_t  access size
req_unsigned  input  1  loads only: zero-extend (LBU/LHU)
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data, right-justified
resp_valid  output  1  completion available
resp_ready  input  1  hart consumes completion
resp_rdata  output  XLEN  extended load data; 0 for stores and faults
resp_misaligned  output  1  access faulted on alignment
mem_req_valid  output  1  memory request
mem_req_ready  input  1  memory accepts request
mem_addr  output  XLEN  word address, low 2 bits always 0
mem_we  output  1  write enable
mem_wstrb  output  STRB_W  byte-lane enables
mem_wdata  output  XLEN  lane-shifted store data
mem_rsp_valid  input  1  read data valid, single-cycle pulse
mem_rdata  input  XLEN  read word

Behaviour:
- Reset (async, reset_n=0): state IDLE; req_ready=1; resp_valid=0; mem_req_valid=0; mem_we=0; mem_wstrb=0; resp_rdata=0; resp_misaligned=0; all captured request registers=0.
- FSM states: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE: req_ready=1. On req_valid, capture all req_* fields. Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0. If misaligned, go to RESP with resp_misaligned=1 and resp_rdata=0. Otherwise go to ISSUE.
- ISSUE: mem_req_valid=1 and all mem_* outputs held stable until mem_req_ready. mem_addr = {addr[XLEN-1:2],2'b00}.
- Store strobes: byte -> 4'b0001<<addr[1:0]; halfword -> 4'b0011<<addr[1:0]; word -> 4'b1111. mem_wdata = wdata<<(8*addr[1:0]). mem_we=1.
- Load strobes: mem_wstrb=0, mem_we=0.
- On the mem_req_ready handshake: a store goes to RESP; a load goes to WAIT_RSP.
- WAIT_RSP: wait for mem_rsp_valid. Extract the lane as mem_rdata>>(8*addr[1:0]), truncate to the access width, then sign- or zero-extend per req_unsigned and register it into resp_rdata. Go to RESP.
- mem_rsp_valid arriving in any state other than WAIT_RSP is ignored.
- RESP: resp_valid=1; resp_rdata and resp_misaligned held stable. On resp_ready, go to IDLE and clear resp_valid.
- req_ready is 0 in every state except IDLE. No new request is accepted in the same cycle as the resp handshake.
- Minimum latency from request accept to resp_valid:
  - misaligned: 1 cycle
  - store: 2 cycles, with mem_req_ready=1
  - load: 3 cycles, with same-cycle ready and next-cycle rsp
- req_unsigned is ignored for word loads and for stores.
- Reset mid-transaction abandons it immediately; there are no residual mem_req_valid or resp_valid pulses.

Decomposition:
- Add to isa_types:
  - lsu_state_t enum {LSU_IDLE, LSU_ISSUE, LSU_WAIT_RSP, LSU_RESP}
  - mem_req_t struct {addr, we, wstrb, wdata}
  - function is_misaligned(write_width_t, logic[1:0])
- Sub-module ls_lane_align: purely combinational. Inputs are width, offset, unsigned, wdata and rdata. Outputs are wstrb, shifted wdata and extended rdata. It is shared by the store and load paths, and the FSM stays in mem_access_unit.

Test Plan:
- Store byte, addr 0x1003, wdata 0xAB, mem_req_ready=1 -> mem_addr 0x1000, wstrb 4'b1000, mem_wdata 0xAB000000; resp_valid 2 cycles after accept, rdata 0, misaligned 0.
- Load halfword signed, addr 0x2002, mem_rdata 0x8001_1234 -> resp_rdata 0xFFFF8001. Same access unsigned -> 0x00008001.
- Load word at addr 0x3001 -> no mem_req_valid ever asserted; resp_valid 1 cycle after accept, misaligned 1, rdata 0.
- Store word with mem_req_ready held 0 for 5 cycles -> mem_* outputs stable all 5 cycles; req_ready 0 throughout; single resp after handshake.
- Load byte, addr 0x11, resp_ready held 0 for 3 cycles -> resp_valid and rdata stable; new req_valid not accepted until the cycle after the resp handshake.
- reset_n pulsed low in WAIT_RSP, then a stray mem_rsp_valid -> outputs at reset values, state IDLE, stray rsp ignored, no resp_valid.
